// File: rtl/pp_sched_pkg.sv
// Shared types and defaults for the ping-pong frame scheduler.
// Build option: PP_SCHED_STATS_EN enables the drop/short statistics counters.
package pp_sched_pkg;

    localparam int unsigned FRAME_PIX_DEF = 76800;
    localparam int unsigned ADDR_W_DEF    = 18;
    localparam int unsigned CNT_W         = 8;

    typedef enum logic [0:0] {
        W_IDLE,
        W_ACTIVE
    } w_state_e;

endpackage

// File: rtl/pp_wr_addr_gen.sv
// Pixel counter, sticky overflow flag and registered RAM write port.
// frame_full reports the count including the pixel presented this cycle.
module pp_wr_addr_gen
    import pp_sched_pkg::*;
#(
    parameter int unsigned FRAME_PIX = FRAME_PIX_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              RST_N,
    input  logic              active,
    input  logic              start,
    input  logic              pix,
    input  logic              din,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_dout,
    output logic              frame_full
);

    // One extra bit so the counter can hold FRAME_PIX even when it equals 2^ADDR_W.
    localparam int unsigned CNT_BITS = ADDR_W + 1;
    localparam logic [CNT_BITS-1:0] FRAME_CNT = CNT_BITS'(FRAME_PIX);
    localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);

    logic [CNT_BITS-1:0] cnt_q, cnt_d, base;
    logic                ovf_q, ovf_d, take, accept;
    logic                wr_en_q, wr_dout_q;
    logic [ADDR_W-1:0]   wr_addr_q;

    // A start pulse restarts the frame before the coincident pixel is considered.
    always_comb begin
        base       = start ? '0 : cnt_q;
        take       = pix && (active || start);
        accept     = take && (base < FRAME_CNT);
        cnt_d      = accept ? base + CNT_ONE : base;
        ovf_d      = (ovf_q && !start) || (take && !accept);
        frame_full = !ovf_d && (cnt_d == FRAME_CNT);
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_dout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            wr_en_q   <= accept;
            wr_addr_q <= base[ADDR_W-1:0];
            wr_dout_q <= din;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_dout = wr_dout_q;

endmodule

// File: rtl/pp_frame_sched.sv
// Ping-pong frame scheduler: write addressing, bank ownership and frame handoff.
// Build option: PP_SCHED_STATS_EN implements drop_cnt/short_cnt, otherwise both read 0.
module pp_frame_sched
    import pp_sched_pkg::*;
#(
    parameter int unsigned FRAME_PIX = FRAME_PIX_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              RST_N,
    input  logic              wr_sof,
    input  logic              wr_eof,
    input  logic              wr_pix,
    input  logic              wr_din,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_dout,
    output logic              wr_bank,
    input  logic              rd_sof,
    output logic              rd_bank,
    output logic              frame_ready,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  short_cnt
);

    w_state_e state_q;
    logic     frame_ready_q, rd_bank_q;
    logic     swap, full, active;

    assign active = (state_q == W_ACTIVE);
    assign swap   = rd_sof && frame_ready_q;

    pp_wr_addr_gen #(
        .FRAME_PIX (FRAME_PIX),
        .ADDR_W    (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .RST_N      (RST_N),
        .active     (active),
        .start      (wr_sof),
        .pix        (wr_pix),
        .din        (wr_din),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_dout    (wr_dout),
        .frame_full (full)
    );

    // frame_ready is only ever 1 while idle, so a completing eof never races a swap.
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= W_IDLE;
            frame_ready_q <= 1'b0;
            rd_bank_q     <= 1'b0;
        end else begin
            if (swap) begin
                rd_bank_q     <= ~rd_bank_q;
                frame_ready_q <= 1'b0;
            end
            case (state_q)
                W_IDLE: begin
                    if (wr_sof) begin
                        state_q       <= W_ACTIVE;
                        frame_ready_q <= 1'b0;
                    end
                end
                W_ACTIVE: begin
                    if (!wr_sof && wr_eof) begin
                        state_q <= W_IDLE;
                        if (full) begin
                            frame_ready_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= W_IDLE;
            endcase
        end
    end

    assign rd_bank     = rd_bank_q;
    assign wr_bank     = ~rd_bank_q;
    assign frame_ready = frame_ready_q;

`ifdef PP_SCHED_STATS_EN
    localparam logic [CNT_W-1:0] STAT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] drop_q, short_q;
    logic             drop_inc, short_inc;

    // A coincident swap frees the ready frame for display, so it is not a drop.
    assign drop_inc  = !active && wr_sof && frame_ready_q && !rd_sof;
    assign short_inc = active && (wr_sof || (wr_eof && !full));

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            drop_q  <= '0;
            short_q <= '0;
        end else begin
            if (drop_inc && (drop_q != '1)) begin
                drop_q <= drop_q + STAT_ONE;
            end
            if (short_inc && (short_q != '1)) begin
                short_q <= short_q + STAT_ONE;
            end
        end
    end

    assign drop_cnt  = drop_q;
    assign short_cnt = short_q;
`else
    assign drop_cnt  = '0;
    assign short_cnt = '0;
`endif

endmodule

// File: tb/tb_pp_frame_sched.sv
// Scoreboard bench for pp_frame_sched, run with a small frame size.
// Directed handoff/overflow/reset cases followed by randomized frames.
module tb_pp_frame_sched;

    localparam int unsigned FP = 64;
    localparam int unsigned AW = 6;
`ifdef PP_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          RST_N = 1'b0;
    logic          wr_sof = 1'b0, wr_eof = 1'b0, wr_pix = 1'b0, wr_din = 1'b0, rd_sof = 1'b0;
    logic          wr_en, wr_dout, wr_bank, rd_bank, frame_ready;
    logic [AW-1:0] wr_addr;
    logic [7:0]    drop_cnt, short_cnt;

    always #5 clk = ~clk;

    pp_frame_sched #(
        .FRAME_PIX (FP),
        .ADDR_W    (AW)
    ) dut (
        .clk         (clk),
        .RST_N       (RST_N),
        .wr_sof      (wr_sof),
        .wr_eof      (wr_eof),
        .wr_pix      (wr_pix),
        .wr_din      (wr_din),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_dout     (wr_dout),
        .wr_bank     (wr_bank),
        .rd_sof      (rd_sof),
        .rd_bank     (rd_bank),
        .frame_ready (frame_ready),
        .drop_cnt    (drop_cnt),
        .short_cnt   (short_cnt)
    );

    int vectors = 0;
    int miscompares = 0;
    int checks = 0;

    // Expected RAM writes as {addr, data}
    logic [AW:0] exp_q[$];

    // Behavioural model of the frame handoff
    bit m_active, m_ready, m_rd_bank, m_ovf;
    int m_cnt, m_drop, m_short;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Monitor: every write must match the oldest expectation, and none may be left pending.
    always @(negedge clk) begin
        logic [AW:0] e;
        if (RST_N) begin
            if (wr_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL wr_unexpected got addr=%0d want no write", wr_addr);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if ({wr_addr, wr_dout} !== e) begin
                        miscompares++;
                        $display("FAIL wr_data got addr=%0d dout=%0d want addr=%0d dout=%0d",
                                 wr_addr, wr_dout, e[AW:1], e[0]);
                    end
                end
            end
            checks++;
            if (exp_q.size() != 0) begin
                miscompares++;
                $display("FAIL wr_missing got no write want addr=%0d", exp_q[0][AW:1]);
                exp_q.delete();
            end
        end
    end

    task automatic model_reset();
        m_active = 0; m_ready = 0; m_rd_bank = 0; m_ovf = 0;
        m_cnt = 0; m_drop = 0; m_short = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input bit sof, input bit eof, input bit pix, input bit din,
                              input bit rsof);
        bit swap;
        bit set_ready;
        logic [AW:0] item;
        swap = rsof && m_ready;
        set_ready = 0;
        if (sof) begin
            if (m_active) m_short = sat(m_short + 1);
            else if (m_ready && !swap) begin
                m_drop = sat(m_drop + 1);
                m_ready = 0;
            end
            m_active = 1; m_cnt = 0; m_ovf = 0;
        end
        if (pix && m_active) begin
            if (m_cnt < FP) begin
                item = {m_cnt[AW-1:0], din};
                exp_q.push_back(item);
                m_cnt++;
            end else begin
                m_ovf = 1;
            end
        end
        if (eof && m_active && !sof) begin
            m_active = 0;
            if (m_cnt == FP && !m_ovf) set_ready = 1;
            else m_short = sat(m_short + 1);
        end
        if (swap) begin
            m_rd_bank = !m_rd_bank;
            m_ready = 0;
        end
        if (set_ready) m_ready = 1;
    endtask

    task automatic check_status();
        chk("rd_bank", 32'(rd_bank), 32'(m_rd_bank));
        chk("wr_bank", 32'(wr_bank), 32'(!m_rd_bank));
        chk("frame_ready", 32'(frame_ready), 32'(m_ready));
        chk("drop_cnt", 32'(drop_cnt), STATS ? 32'(m_drop) : 32'd0);
        chk("short_cnt", 32'(short_cnt), STATS ? 32'(m_short) : 32'd0);
    endtask

    // Called at posedge+1; applies one cycle of inputs and checks the result.
    task automatic drive(input bit sof, input bit eof, input bit pix, input bit rsof);
        bit din;
        din = 1'($urandom);
        wr_sof = sof; wr_eof = eof; wr_pix = pix; wr_din = din; rd_sof = rsof;
        @(posedge clk);
        #1;
        vectors++;
        wr_sof = 0; wr_eof = 0; wr_pix = 0; rd_sof = 0;
        model_step(sof, eof, pix, din, rsof);
        check_status();
    endtask

    task automatic pixels(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 1, 0);
    endtask

    task automatic full_frame();
        drive(1, 0, 0, 0);
        pixels(FP);
        drive(0, 1, 0, 0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_wr_en"}, 32'(wr_en), 0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
        chk({tag, "_wr_dout"}, 32'(wr_dout), 0);
        chk({tag, "_wr_bank"}, 32'(wr_bank), 1);
        chk({tag, "_rd_bank"}, 32'(rd_bank), 0);
        chk({tag, "_frame_ready"}, 32'(frame_ready), 0);
        chk({tag, "_drop_cnt"}, 32'(drop_cnt), 0);
        chk({tag, "_short_cnt"}, 32'(short_cnt), 0);
    endtask

    initial begin
        int len;
        int kind;
        model_reset();
        #3;
        check_reset_values("reset");
        #14 RST_N = 1'b1;
        @(posedge clk);
        #1;

        // Full frame, then handoff
        full_frame();
        chk("full_ready", 32'(frame_ready), 1);
        drive(0, 0, 0, 1);
        chk("full_swap_rd_bank", 32'(rd_bank), 1);

        // Short frame: no ready, swap request ignored
        drive(1, 0, 0, 0); pixels(10); drive(0, 1, 0, 0);
        drive(0, 0, 0, 1);

        // Overflow: extra pixels discarded, frame counts as short
        drive(1, 0, 0, 0); pixels(FP + 10); drive(0, 1, 0, 0);
        drive(0, 0, 0, 1);

        // Two full frames without a reader swap: first one dropped
        full_frame(); full_frame();
        drive(0, 0, 0, 1);

        // eof coincident with rd_sof: no swap until the next rd_sof
        drive(1, 0, 0, 0); pixels(FP); drive(0, 1, 0, 1);
        chk("eof_rsof_ready", 32'(frame_ready), 1);
        drive(0, 0, 0, 0);
        // sof coincident with rd_sof while ready: swap wins, no drop
        drive(1, 0, 0, 1);
        chk("sof_rsof_bank", 32'(wr_bank), 32'(!rd_bank));

        // Pixel with sof lands at address 0; pixel with eof completes the frame
        drive(0, 1, 1, 0);
        drive(1, 0, 1, 0); pixels(FP - 2); drive(0, 1, 1, 0);
        drive(0, 0, 0, 1);

        // Stray eof while idle is ignored
        drive(0, 1, 1, 0);

        // Reset mid-frame
        drive(1, 0, 0, 0); pixels(30); drive(0, 0, 0, 0);
        RST_N = 1'b0;
        #1;
        model_reset();
        check_reset_values("midreset");
        #6 RST_N = 1'b1;
        @(posedge clk);
        #1;
        full_frame();
        chk("after_reset_ready", 32'(frame_ready), 1);
        drive(0, 0, 0, 1);

        // Randomized frames with independent reader strobes
        for (int f = 0; f < 80; f++) begin
            len = $urandom_range(3, 0);
            for (int g = 0; g < len; g++) drive(0, ($urandom_range(9, 0) == 0), 0,
                                               ($urandom_range(9, 0) == 0));
            kind = $urandom_range(9, 0);
            if (kind < 5) len = FP;
            else if (kind < 7) len = FP - 1 - $urandom_range(FP / 2, 0);
            else len = FP + 1 + $urandom_range(4, 0);
            drive(1, 0, ($urandom_range(3, 0) == 0), ($urandom_range(7, 0) == 0));
            for (int p = 0; p < len + 8; p++) begin
                if (m_cnt >= len || (m_ovf && m_cnt >= FP)) break;
                drive(0, 0, ($urandom_range(5, 0) != 0), ($urandom_range(19, 0) == 0));
            end
            if ($urandom_range(11, 0) != 0)
                drive(0, 1, 0, ($urandom_range(3, 0) == 0));
        end
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
